// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-port register file: default geometry, dump FSM encoding
// and the link-address helper.
package reg_file_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_DEPTH  = 32;

   // Link values are shifted at this width, then truncated to DATA_W (so DATA_W <= 64).
   localparam int unsigned LINK_MAX_W = 64;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DUMP = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   function automatic logic [LINK_MAX_W-1:0] link_shift(input logic [LINK_MAX_W-1:0] pc,
                                                        input int unsigned shift);
      return pc << shift;
   endfunction

endpackage

// File: rtl/reg_file_dump_fsm.sv
// Dump engine for reg_file_mp: walks every register index once under a valid/ready
// handshake and pulses dump_done after the last beat is accepted.
module reg_file_dump_fsm
   import reg_file_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              dump_req,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic              dump_done,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (dump_req) begin
               state_d = DUMP;
               addr_d  = '0;
            end
         end
         DUMP: begin
            // A stalled beat keeps both state and index untouched.
            if (dump_ready) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = DONE;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            addr_d  = '0;
         end
         default: begin
            state_d = IDLE;
            addr_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   assign dump_valid = (state_q == DUMP);
   assign dump_done  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign dump_addr  = addr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised CPU register file: two combinational read ports, negedge general and link
// writes, async clear and a handshaked dump port. REG_FILE_BYPASS_EN adds write-to-read bypass.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned ADDR_W     = $clog2(DEPTH),
   parameter int unsigned LINK_REG   = DEPTH - 1,
   parameter int unsigned LINK_SHIFT = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] read_add1,
   input  logic [ADDR_W-1:0] read_add2,
   output logic [DATA_W-1:0] read_out_data1,
   output logic [DATA_W-1:0] read_out_data2,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] write_add,
   input  logic [DATA_W-1:0] write_data,
   input  logic              Jal_WB_W,
   input  logic [DATA_W-1:0] link_data,
   input  logic              dump_req,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_done,
   output logic              busy
);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] link_val;
   logic [ADDR_W-1:0] link_add;

   assign link_add = ADDR_W'(LINK_REG);
   assign link_val = DATA_W'(link_shift(LINK_MAX_W'(link_data), LINK_SHIFT));

   // Register 0 is cleared by reset and never written, so it reads 0 without a read mux.
   // The link write is issued last so it wins when both ports target LINK_REG.
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         regs_q <= '{default: '0};
      end else begin
         if (RegWrite && (write_add != '0)) begin
            regs_q[write_add] <= write_data;
         end
         if (Jal_WB_W) begin
            regs_q[link_add] <= link_val;
         end
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] add);
      logic [DATA_W-1:0] val;
      val = regs_q[add];
`ifdef REG_FILE_BYPASS_EN
      if (RegWrite && (write_add == add) && (add != '0)) begin
         val = write_data;
      end
      if (Jal_WB_W && (add == link_add)) begin
         val = link_val;
      end
`endif
      return val;
   endfunction

   always_comb begin
      read_out_data1 = read_port(read_add1);
      read_out_data2 = read_port(read_add2);
   end

   reg_file_dump_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_dump_fsm (
      .CLK        (CLK),
      .RST        (RST),
      .dump_req   (dump_req),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_addr  (dump_addr),
      .dump_done  (dump_done),
      .busy       (busy)
   );

   // Live read: a beat reflects the register as it stands when the beat is accepted.
   assign dump_data = regs_q[dump_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expected reads/beats/done events into
// queues; monitors pop and compare when the DUT presents them.
`timescale 1ns/1ps
module tb_reg_file_mp;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [4:0]  read_add1 = '0, read_add2 = '0, write_add = '0;
   logic [31:0] read_out_data1, read_out_data2;
   logic        RegWrite = 1'b0, Jal_WB_W = 1'b0;
   logic [31:0] write_data = '0, link_data = '0;
   logic        dump_req = 1'b0, dump_ready = 1'b1;
   logic        dump_valid, dump_done, busy;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;

   always #5 CLK = ~CLK;

   reg_file_mp dut (
      .CLK            (CLK),
      .RST            (RST),
      .read_add1      (read_add1),
      .read_add2      (read_add2),
      .read_out_data1 (read_out_data1),
      .read_out_data2 (read_out_data2),
      .RegWrite       (RegWrite),
      .write_add      (write_add),
      .write_data     (write_data),
      .Jal_WB_W       (Jal_WB_W),
      .link_data      (link_data),
      .dump_req       (dump_req),
      .dump_valid     (dump_valid),
      .dump_ready     (dump_ready),
      .dump_addr      (dump_addr),
      .dump_data      (dump_data),
      .dump_done      (dump_done),
      .busy           (busy)
   );

   typedef struct {
      string       name;
      logic [31:0] d1;
      logic [31:0] d2;
   } rd_exp_t;
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } beat_t;
   typedef struct {
      int beats;
      int cycles;  // 0: cycle count not checked
   } done_t;

   rd_exp_t     rd_q[$];
   rd_exp_t     early_q[$];
   beat_t       beat_q[$];
   done_t       done_q[$];
   logic        rd_strobe = 1'b0, early_strobe = 1'b0;
   int          errors = 0, checks = 0;
   int          mon_beats = 0, mon_cyc = 0;
   logic [31:0] model [32];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event, required none", name);
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : model[a];
   endfunction

   // Late monitor: second half of the cycle, after the negedge write.
   initial begin
      rd_exp_t e;
      beat_t   b;
      done_t   d;
      forever begin
         @(negedge CLK);
         #1;
         if (rd_strobe) begin
            if (rd_q.size() == 0) fail("read queue underflow");
            else begin
               e = rd_q.pop_front();
               chk({e.name, "/p1"}, read_out_data1, e.d1);
               chk({e.name, "/p2"}, read_out_data2, e.d2);
            end
         end
         if (RST) begin
            mon_beats = 0;
            mon_cyc   = 0;
         end else begin
            if (busy) mon_cyc++;
            if (dump_valid && dump_ready) begin
               if (beat_q.size() == 0) fail("unexpected beat");
               else begin
                  b = beat_q.pop_front();
                  chk("beat addr", 32'(dump_addr), 32'(b.addr));
                  chk("beat data", dump_data, b.data);
               end
               mon_beats++;
            end
            if (dump_done) begin
               if (done_q.size() == 0) fail("unexpected dump_done");
               else begin
                  d = done_q.pop_front();
                  chk("done beats", mon_beats, d.beats);
                  if (d.cycles != 0) chk("done cycles", mon_cyc, d.cycles);
               end
               mon_beats = 0;
               mon_cyc   = 0;
            end
         end
      end
   end

   // Early monitor: first half of the cycle, before the negedge write.
   initial begin
      rd_exp_t e;
      forever begin
         @(posedge CLK);
         #3;
         if (early_strobe) begin
            if (early_q.size() == 0) fail("early queue underflow");
            else begin
               e = early_q.pop_front();
               chk({e.name, "/early"}, read_out_data2, e.d2);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic jal, input logic [31:0] ld);
      RegWrite = we; write_add = wa; write_data = wd; Jal_WB_W = jal; link_data = ld;
      if (we && wa != 5'd0) model[wa] = wd;
      if (jal) model[31] = {ld[29:0], 2'b00};
   endtask

   // One cycle: optional write, then both ports checked after the negedge.
   task automatic wr_rd(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic jal, input logic [31:0] ld,
                        input logic [4:0] a1, input logic [4:0] a2, input string name);
      rd_exp_t e;
      drive(we, wa, wd, jal, ld);
      read_add1 = a1; read_add2 = a2;
      e.name = name; e.d1 = mread(a1); e.d2 = mread(a2);
      rd_q.push_back(e);
      rd_strobe = 1'b1;
      tick();
      RegWrite = 1'b0; Jal_WB_W = 1'b0; rd_strobe = 1'b0;
   endtask

   // Port 2 sampled before the negedge (exp_on/exp_off by bypass build), then after it.
   task automatic early_rd(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic jal, input logic [31:0] ld, input logic [4:0] a2,
                           input logic [31:0] exp_on, input logic [31:0] exp_off,
                           input logic [31:0] exp_late, input string name);
      rd_exp_t e;
      drive(we, wa, wd, jal, ld);
      read_add1 = a2; read_add2 = a2;
      e.name = name; e.d1 = exp_late; e.d2 = exp_off;
`ifdef REG_FILE_BYPASS_EN
      e.d2 = exp_on;
`endif
      early_q.push_back(e);
      e.d2 = exp_late;
      rd_q.push_back(e);
      early_strobe = 1'b1; rd_strobe = 1'b1;
      tick();
      RegWrite = 1'b0; Jal_WB_W = 1'b0; early_strobe = 1'b0; rd_strobe = 1'b0;
   endtask

   task automatic start_dump(input int cycles);
      beat_t b;
      done_t d;
      for (int i = 0; i < 32; i++) begin
         b.addr = 5'(i); b.data = mread(5'(i));
         beat_q.push_back(b);
      end
      d.beats = 32; d.cycles = cycles;
      done_q.push_back(d);
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
   endtask

   task automatic wait_done(input string name, input logic toggle, input int req_at);
      int n = 0;
      while (done_q.size() != 0 && n < 300) begin
         if (toggle) dump_ready = ~dump_ready;
         dump_req = (n == req_at);
         tick();
         n++;
      end
      dump_req = 1'b0; dump_ready = 1'b1;
      checks++;
      if (done_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got no dump_done within %0d cycles, required a pulse", name, n);
         beat_q.delete(); done_q.delete();
      end
      tick();
      chk({name, " idle busy"}, 32'(busy), 32'd0);
      chk({name, " idle valid"}, 32'(dump_valid), 32'd0);
      chk({name, " idle addr"}, 32'(dump_addr), 32'd0);
   endtask

   task automatic check_idle_reset(input string name);
      chk({name, " busy"}, 32'(busy), 32'd0);
      chk({name, " valid"}, 32'(dump_valid), 32'd0);
      chk({name, " done"}, 32'(dump_done), 32'd0);
      chk({name, " addr"}, 32'(dump_addr), 32'd0);
   endtask

   task automatic pulse_reset(input string name);
      RST = 1'b1;
      beat_q.delete(); done_q.delete();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      tick();
      check_idle_reset(name);
      RST = 1'b0;
      tick();
      check_idle_reset({name, " after"});
   endtask

   initial begin
      int n;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      #2 RST = 1'b1;
      tick();
      check_idle_reset("power-on reset");
      RST = 1'b0;
      tick();

      // Random writes, then a reset must clear everything.
      for (int i = 1; i < 32; i += 3) wr_rd(1'b1, 5'(i), $urandom(), 1'b0, 32'd0,
                                            5'(i), 5'(i - 1), "rand write");
      pulse_reset("mid reset");
      for (int i = 0; i < 32; i += 2) wr_rd(1'b0, 5'd0, 32'd0, 1'b0, 32'd0,
                                            5'(i), 5'(i + 1), "post-reset zero");

      // Directed writes.
      wr_rd(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 5'd5, 5'd0, "write r5");
      wr_rd(1'b1, 5'd0, 32'h00001234, 1'b0, 32'd0, 5'd0, 5'd5, "write r0 discarded");
      wr_rd(1'b1, 5'd31, 32'd7, 1'b1, 32'h100, 5'd31, 5'd5, "link beats write");
      wr_rd(1'b1, 5'd31, 32'd7, 1'b0, 32'd0, 5'd31, 5'd0, "plain write r31");
      wr_rd(1'b0, 5'd0, 32'd0, 1'b1, 32'hC0000001, 5'd31, 5'd5, "link truncation");

      // Same-cycle reads before the negedge.
      wr_rd(1'b1, 5'd3, 32'h55, 1'b0, 32'd0, 5'd3, 5'd0, "seed r3");
      early_rd(1'b1, 5'd3, 32'd9, 1'b0, 32'd0, 5'd3, 32'd9, 32'h55, 32'd9, "bypass r3");
      early_rd(1'b1, 5'd0, 32'hAB, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, "bypass r0");
      wr_rd(1'b1, 5'd31, 32'h31313131, 1'b0, 32'd0, 5'd31, 5'd3, "seed r31");
      early_rd(1'b1, 5'd31, 32'd7, 1'b1, 32'h10, 5'd31, 32'h40, 32'h31313131, 32'h40,
               "bypass link");

      // Fill for dumps.
      for (int i = 1; i < 32; i++) wr_rd(1'b1, 5'(i), 32'hA5000000 | 32'(i * 17), 1'b0, 32'd0,
                                        5'(i), 5'(i - 1), "fill");

      dump_ready = 1'b1;
      start_dump(33);
      wait_done("dump full-rate", 1'b0, 5);

      start_dump(0);
      wait_done("dump toggled ready", 1'b1, -1);

      // Abort once ten beats have gone out.
      start_dump(0);
      n = 0;
      while (mon_beats < 10 && n < 100) begin
         tick();
         n++;
      end
      chk("abort reached beat 10", mon_beats, 32'd10);
      pulse_reset("dump abort");
      repeat (40) tick();
      wr_rd(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd31, 5'd5, "after abort zero");

      repeat (3) tick();
      chk("read queue drained", rd_q.size(), 32'd0);
      chk("early queue drained", early_q.size(), 32'd0);
      chk("beat queue drained", beat_q.size(), 32'd0);
      chk("done queue drained", done_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
